// File: rtl/switch_vc_arbiter_if.sv
// Handshake bundle between the VC arbiter, the four VC buffers and the
// 4:1 switch mux. The arbiter takes the master view; buffers and the
// downstream link side take the slave view.
interface switch_vc_arbiter_if;
    logic [3:0] req;
    logic [3:0] last;
    logic       out_ready;
    logic [1:0] sel;
    logic       oe;
    logic [3:0] gnt;
    logic       xfer;
    logic       busy;
    logic       timeout_err;

    modport master (
        input  req, last, out_ready,
        output sel, oe, gnt, xfer, busy, timeout_err
    );

    modport slave (
        output req, last, out_ready,
        input  sel, oe, gnt, xfer, busy, timeout_err
    );
endinterface

// File: rtl/switch_vc_arbiter.sv
// Packet-granular round-robin arbiter for the 4:1 VC switch mux.
// A winning VC keeps the mux until its tail flit moves, or until the
// watchdog forces release after TIMEOUT cycles in GRANT.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; registers the round-robin decision when req != 0
// GRANT | mux locked to sel until tail flit transfers or watchdog fires
module switch_vc_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    switch_vc_arbiter_if.master  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    // Watchdog fires when the cycle counter reaches this value.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [1:0] sel;
    logic       oe;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout_err;
    logic [1:0] rr_ptr;
    logic [7:0] cyc_cnt;

    logic       xfer;
    logic       tail_xfer;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;

    assign xfer      = busy & bus.req[sel] & bus.out_ready;
    assign tail_xfer = xfer & bus.last[sel];

    assign bus.sel         = sel;
    assign bus.oe          = oe;
    assign bus.gnt         = gnt;
    assign bus.busy        = busy;
    assign bus.xfer        = xfer;
    assign bus.timeout_err = timeout_err;

    // First requesting VC at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        winner = rr_ptr;
        idx    = rr_ptr;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Grant FSM with registered mux controls, round-robin pointer and watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= 2'b00;
            oe          <= 1'b0;
            gnt         <= 4'b0000;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= 2'd0;
            cyc_cnt     <= 8'd0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        sel     <= winner;
                        gnt     <= 4'b0001 << winner;
                        oe      <= 1'b1;
                        busy    <= 1'b1;
                        cyc_cnt <= 8'd0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (cyc_cnt != 8'hFF) begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                    // Tail transfer wins over the watchdog in the same cycle.
                    if (tail_xfer || (cyc_cnt == TO_LAST)) begin
                        state       <= IDLE;
                        oe          <= 1'b0;
                        gnt         <= 4'b0000;
                        busy        <= 1'b0;
                        rr_ptr      <= sel + 2'd1;
                        timeout_err <= ~tail_xfer;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_vc_arbiter.sv
// Self-checking bench for switch_vc_arbiter: a table of directed vectors,
// hand-written corner sequences and randomized traffic against a
// transaction-level reference model.
module tb_switch_vc_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    switch_vc_arbiter_if bus ();

    switch_vc_arbiter #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the link, how long it has held it,
    // where the next search starts, and the last selected VC.
    int m_owner;
    int m_age;
    int m_rr;
    int m_sel;
    int m_err;

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        logic       rdy;
        logic       x_xfer;
        logic [3:0] x_gnt;
        logic [1:0] x_sel;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_rr    = 0;
        m_sel   = 0;
        m_err   = 0;
    endtask

    function automatic int model_xfer(input logic [3:0] r, input logic rd);
        return (m_owner >= 0 && r[m_owner] && rd) ? 1 : 0;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic rd);
        int done;
        int v;
        m_err = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                v = (m_rr + k) % 4;
                if (m_owner < 0 && r[v]) begin
                    m_owner = v;
                    m_sel   = v;
                    m_age   = 0;
                end
            end
        end else begin
            done = model_xfer(r, rd) && l[m_owner];
            if (done || m_age == TO - 1) begin
                m_rr    = (m_owner + 1) % 4;
                m_owner = -1;
                m_err   = done ? 0 : 1;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_regs(input string tag);
        int xg;
        xg = (m_owner >= 0) ? (1 << m_owner) : 0;
        check({tag, ".gnt"}, int'(bus.gnt), xg);
        check({tag, ".sel"}, int'(bus.sel), m_sel);
        check({tag, ".oe"}, int'(bus.oe), (m_owner >= 0) ? 1 : 0);
        check({tag, ".busy"}, int'(bus.busy), (m_owner >= 0) ? 1 : 0);
        check({tag, ".timeout_err"}, int'(bus.timeout_err), m_err);
    endtask

    // One clock: drive inputs, check xfer mid-cycle, clock, check registers.
    task automatic apply(input logic [3:0] r, input logic [3:0] l, input logic rd,
                         input string tag, output logic x_seen);
        int xe;
        bus.req       = r;
        bus.last      = l;
        bus.out_ready = rd;
        @(negedge clk);
        xe     = model_xfer(r, rd);
        x_seen = bus.xfer;
        check({tag, ".xfer"}, int'(bus.xfer), xe);
        @(posedge clk);
        model_step(r, l, rd);
        #1;
        check_regs(tag);
    endtask

    task automatic do_reset(input int cycles);
        rst           = 1'b1;
        bus.req       = 4'b0000;
        bus.last      = 4'b0000;
        bus.out_ready = 1'b0;
        model_reset();
        #1;
        check_regs("reset");
        repeat (cycles) @(posedge clk);
        #1;
        check_regs("reset_hold");
        rst = 1'b0;
    endtask

    initial begin
        logic       xs;
        logic [3:0] prev_gnt;
        int         flits;
        int         n;
        int         order[$];
        logic [3:0] rl;

        bus.req       = 4'b0000;
        bus.last      = 4'b0000;
        bus.out_ready = 1'b0;
        model_reset();

        // Reset then idle.
        do_reset(3);
        for (int i = 0; i < 10; i++) apply(4'b0000, 4'b0000, 1'b1, "idle", xs);

        // Directed vectors starting from rr_ptr = 0.
        tbl[0]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0100, 2'd2};
        tbl[1]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2};
        tbl[2]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2};
        tbl[3]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0000, 2'd2};
        tbl[4]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1000, 2'd3};
        tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd3};
        tbl[6]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0};
        tbl[7]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0};
        tbl[8]  = '{4'b1110, 4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0};
        tbl[9]  = '{4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0};
        tbl[10] = '{4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0000, 2'd0};
        tbl[11] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001, 2'd0};
        tbl[12] = '{4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0000, 2'd0};
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].req, tbl[i].last, tbl[i].rdy, "tbl", xs);
            check($sformatf("tbl%0d.xfer", i), int'(xs), int'(tbl[i].x_xfer));
            check($sformatf("tbl%0d.gnt", i), int'(bus.gnt), int'(tbl[i].x_gnt));
            check($sformatf("tbl%0d.sel", i), int'(bus.sel), int'(tbl[i].x_sel));
            check($sformatf("tbl%0d.oe", i), int'(bus.oe), (tbl[i].x_gnt != 0) ? 1 : 0);
        end

        // Round-robin fairness with 2-flit packets.
        do_reset(2);
        prev_gnt = 4'b0000;
        flits    = 0;
        for (int i = 0; i < 13; i++) begin
            rl = (flits == 1) ? 4'b1111 : 4'b0000;
            apply(4'b1111, rl, 1'b1, "rr", xs);
            if (xs) flits = (flits == 1) ? 0 : flits + 1;
            if (prev_gnt == 4'b0000 && bus.gnt != 4'b0000) order.push_back(int'(bus.sel));
            prev_gnt = bus.gnt;
        end
        check("rr.count", order.size(), 5);
        for (int k = 0; k < order.size(); k++) begin
            check($sformatf("rr.order%0d", k), order[k], k % 4);
            if (k > 0 && order[k] == order[k-1]) check("rr.repeat", order[k], -1);
        end

        // Lock and stall on VC1.
        do_reset(2);
        apply(4'b0010, 4'b0000, 1'b1, "lock", xs);
        check("lock.gnt", int'(bus.gnt), 4'b0010);
        for (int i = 0; i < 5; i++) begin
            apply(4'b1111, 4'b0000, 1'b0, "stall", xs);
            check("stall.xfer", int'(xs), 0);
            check("stall.gnt", int'(bus.gnt), 4'b0010);
        end
        apply(4'b1111, 4'b0010, 1'b1, "tail", xs);
        check("tail.xfer", int'(xs), 1);
        check("tail.gnt", int'(bus.gnt), 0);
        apply(4'b1111, 4'b0000, 1'b1, "after", xs);
        check("after.gnt", int'(bus.gnt), 4'b0100);

        // Watchdog with VC0 going silent.
        do_reset(2);
        apply(4'b0001, 4'b0000, 1'b1, "wd", xs);
        check("wd.gnt", int'(bus.gnt), 4'b0001);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            apply(4'b1010, 4'b0000, 1'b1, "wd_wait", xs);
            n = i;
            if (bus.gnt == 4'b0000) break;
        end
        check("wd.release_cycles", n, TO);
        check("wd.err_pulse", int'(bus.timeout_err), 1);
        apply(4'b1010, 4'b0000, 1'b1, "wd_next", xs);
        check("wd.err_clear", int'(bus.timeout_err), 0);
        check("wd.next_gnt", int'(bus.gnt), 4'b0010);

        // Async reset mid-packet on VC3.
        do_reset(2);
        apply(4'b1000, 4'b0000, 1'b1, "ar", xs);
        apply(4'b1000, 4'b0000, 1'b1, "ar", xs);
        check("ar.gnt_before", int'(bus.gnt), 4'b1000);
        #3;
        rst = 1'b1;
        #1;
        check("ar.gnt_async", int'(bus.gnt), 0);
        check("ar.oe_async", int'(bus.oe), 0);
        check("ar.busy_async", int'(bus.busy), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(4'b1001, 4'b0000, 1'b1, "ar_after", xs);
        check("ar.winner", int'(bus.gnt), 4'b0001);

        // Randomized traffic against the model.
        do_reset(2);
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r;
            logic [3:0] l;
            logic       rd;
            r  = 4'($urandom_range(0, 15));
            l  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 3) != 0);
            apply(r, l, rd, "rand", xs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/switch_vc_arbiter.md
Name: switch_vc_arbiter

Overview:
Packet-granular round-robin arbiter that sequences the 4:1 virtual-channel switch mux. It drives the mux select and output-enable for four VC buffers competing for one output link. Once a VC wins, the grant is held for the whole packet, up to and including its tail flit. A watchdog forces release of a stalled grant.

Parameters:
TIMEOUT, 64, max cycles a grant may stay in GRANT state before forced release; legal range 2..255.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req  input  4  req[i]=1: VC i has a flit available at mux input i
last  input  4  last[i]=1: the flit currently presented by VC i is a tail flit; qualified only by req[i]
out_ready  input  1  downstream can accept a flit this cycle
sel  output  2  mux select to switch datapath
oe  output  1  mux output enable; 0 puts the mux output in high-Z
gnt  output  4  one-hot grant to VC buffers; 0 when idle
xfer  output  1  combinational: a flit moves this cycle
busy  output  1  1 while in GRANT state
timeout_err  output  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, immediate): state=IDLE, sel=2'b00, oe=0, gnt=4'b0000, busy=0, timeout_err=0, rr_ptr=2'd0, cyc_cnt=8'd0.
- sel, oe, gnt and busy are registered. xfer = busy & req[sel] & out_ready is combinational.
- States: IDLE, GRANT.

IDLE:
- If req==0: stay in IDLE. Outputs hold oe=0 and gnt=0. sel holds its last value.
- If req!=0: the winner is the first set bit searching rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
- At the next edge: sel=winner, gnt=1<<winner, oe=1, busy=1, cyc_cnt=0, state=GRANT.
- Arbitration latency is 1 cycle from req to gnt/oe.

GRANT:
- Grant is locked to sel. Requests from other VCs are ignored.
- Each cycle, cyc_cnt increments, saturating at 255.
- req[sel]=0 or out_ready=0: stall. Hold the grant; no flit moves.
- Normal release: xfer=1 and last[sel]=1. At that edge:
  - state=IDLE, oe=0, gnt=0, busy=0.
  - rr_ptr=sel+1 (mod 4, so 3 wraps to 0).
- Forced release: cyc_cnt==TIMEOUT-1 with no normal release that cycle. At that edge:
  - Same release as the normal case, including rr_ptr=sel+1.
  - timeout_err=1 for exactly one cycle.
- Normal release takes priority over timeout in the same cycle; timeout_err stays 0.
- Release always passes through at least one IDLE cycle, so there is one bubble between packets. That cycle is when the arbitration decision is registered.

Boundary conditions:
- Single-flit packet (last=1 on the first xfer): release after 1 transfer.
- Same VC requesting again after release: it wins only if no other VC requests, because rr_ptr has moved past it.
- rr_ptr updates only on release, never in IDLE without a grant.
- Reset asserted mid-packet: immediate return to the reset values. The in-flight packet is abandoned; upstream handles recovery.
- last[i] with req[i]=0 is ignored.
- gnt is always one-hot or zero. oe==busy==|gnt at all times.

Test Plan:
- Reset then idle: rst high 3 cycles, req=0 for 10 cycles -> oe=0, gnt=0, sel=0, busy=0 throughout.
- Basic packet: req=4'b0100, out_ready=1, last[2]=1 on the 3rd flit.
  - gnt=4'b0100, sel=2, oe=1 one cycle after req.
  - 3 xfer pulses, then gnt=0 the next cycle; rr_ptr=3.
- Round-robin fairness: req=4'b1111 held, every packet 2 flits.
  - Grant order 0,1,2,3,0 with one idle cycle between packets.
  - Never two consecutive grants to the same VC.
- Lock and stall: VC1 granted, out_ready=0 for 5 cycles while req=4'b1111.
  - gnt stays 4'b0010, xfer=0, no switch.
  - Tail completes after out_ready returns -> next grant is VC2.
- Watchdog: TIMEOUT=8; VC0 granted, then req[0]=0 forever.
  - Release 8 cycles after grant; timeout_err one-cycle pulse.
  - Next grant goes to a requesting VC starting from 1.
- Async reset mid-packet: assert rst between clock edges while gnt=4'b1000 -> oe=0 and gnt=0 immediately, before the next edge; after deassert, rr_ptr=0 and VC0 wins over VC3 when req=4'b1001.
